// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with stall, redirect, trap and fault handling
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     IALIGN       = 4,
   parameter int unsigned     INC_BYTES    = 4,
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             trap_req,
   input  logic             pc_ready,
   output logic [XLEN-1:0]  pc_current,
   output logic             pc_valid,
   output logic             fault_valid,
   output logic [XLEN-1:0]  fault_addr,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(IALIGN - 1);
   localparam logic [XLEN-1:0]  PC_INC     = XLEN'(INC_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_t state;
   logic   fetch_accept;
   logic   target_aligned;

   // Only RUN issues fetches; a stall suppresses the request without touching the PC.
   assign pc_valid       = (state == ST_RUN) && !stall;
   assign fetch_accept   = pc_valid && pc_ready;
   assign target_aligned = (redirect_pc & ALIGN_MASK) == '0;

   // State machine owning the PC and the fault record; trap beats redirect beats sequential.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         pc_current  <= RESET_VECTOR;
         fault_valid <= 1'b0;
         fault_addr  <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               if (trap_req) begin
                  pc_current <= TRAP_VECTOR;
               end
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (trap_req) begin
                  pc_current <= TRAP_VECTOR;
               end else if (redirect_valid) begin
                  // Redirects land even under stall; a bad target parks the fetch unit.
                  if (target_aligned) begin
                     pc_current <= redirect_pc;
                  end else begin
                     fault_valid <= 1'b1;
                     fault_addr  <= redirect_pc;
                     state       <= ST_FAULT;
                  end
               end else if (fetch_accept) begin
                  pc_current <= pc_current + PC_INC;
               end
            end
            ST_FAULT: begin
               // Only a trap clears the fault; fault_addr is kept for the handler to read.
               if (trap_req) begin
                  pc_current  <= TRAP_VECTOR;
                  fault_valid <= 1'b0;
                  state       <= ST_RUN;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

   // Saturating count of fetches imem actually accepted, including ones that coincide with a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (fetch_accept && (fetch_count != CNT_MAX)) begin
         fetch_count <= fetch_count + CNT_W'(1);
      end
   end

endmodule
